// File: rtl/mem_p_pkg.sv
// Shared state encoding and default geometry for the P-memory loader.
package mem_p_pkg;

    localparam int unsigned DEFAULT_NUMBER_OF_CLUSTERS = 1;
    localparam int unsigned DEFAULT_EQUATIONS_PER_CLUSTER = 9;
    localparam int unsigned DEFAULT_ELEMENT_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lane_packer.sv
// Packs streamed elements into one wide word, lane 0 in the least significant bits.
module lane_packer #(
    parameter int unsigned lanes = 9,
    parameter int unsigned element_width = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic                             clear,
    input  logic [element_width-1:0]         data,
    output logic [lanes*element_width-1:0]   next_word_c,
    output logic                             full_c
);

    localparam int unsigned WORD_W = lanes * element_width;
    localparam int unsigned LANE_W = (lanes > 1) ? $clog2(lanes) : 1;

    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] word;

    // Current element is the last lane of the word.
    assign full_c = (lane == LANE_W'(lanes - 1));

    // Word as it will look once the element on data is written into the current lane.
    always_comb begin
        next_word_c = word;
        next_word_c[lane*element_width +: element_width] = data;
    end

    // Lane counter and packing register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane <= '0;
            word <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (load) begin
            word <= next_word_c;
            lane <= full_c ? '0 : lane + LANE_W'(1);
        end
    end

endmodule

// File: rtl/mem_p_loader.sv
// Collects streamed elements into wide words and writes one word per cluster to memory.
module mem_p_loader
    import mem_p_pkg::*;
#(
    parameter int unsigned number_of_clusters = DEFAULT_NUMBER_OF_CLUSTERS,
    parameter int unsigned number_of_equations_per_cluster = DEFAULT_EQUATIONS_PER_CLUSTER,
    parameter int unsigned element_width = DEFAULT_ELEMENT_WIDTH,
    parameter int unsigned address_width = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                                                     clk,
    input  logic                                                     rst_n,
    input  logic                                                     start,
    input  logic                                                     in_valid,
    input  logic [element_width-1:0]                                 in_data,
    output logic                                                     in_ready,
    output logic [number_of_equations_per_cluster*element_width-1:0] mem_input_data,
    output logic                                                     mem_write_enable,
    output logic [address_width-1:0]                                 mem_write_address,
    output logic                                                     busy,
    output logic                                                     finish
);

    localparam int unsigned WORD_W = number_of_equations_per_cluster * element_width;
    localparam int unsigned CLUSTER_W = (number_of_clusters > 1) ? $clog2(number_of_clusters) : 1;

    state_t                 state;
    logic [CLUSTER_W-1:0]   cluster;
    logic                   accept_c;
    logic                   clear_c;
    logic                   full_c;
    logic [WORD_W-1:0]      next_word_c;

    // in_ready is a register, so acceptance never feeds back into it within a cycle.
    assign accept_c = in_valid && in_ready;
    // Lane restarts on a new load and between clusters; both cases are outside FILL.
    assign clear_c  = (((state == IDLE) || (state == DONE)) && start) || (state == WRITE);

    lane_packer #(
        .lanes        (number_of_equations_per_cluster),
        .element_width(element_width)
    ) u_lane_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept_c),
        .clear      (clear_c),
        .data       (in_data),
        .next_word_c(next_word_c),
        .full_c     (full_c)
    );

    // Load sequencer: state, cluster counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            cluster           <= '0;
            in_ready          <= 1'b0;
            mem_input_data    <= '0;
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            busy              <= 1'b0;
            finish            <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= FILL;
                        cluster  <= '0;
                        finish   <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept_c && full_c) begin
                        state             <= WRITE;
                        in_ready          <= 1'b0;
                        mem_write_enable  <= 1'b1;
                        mem_write_address <= address_width'(cluster);
                        mem_input_data    <= next_word_c;
                    end
                end
                WRITE: begin
                    mem_write_enable <= 1'b0;
                    if (cluster == CLUSTER_W'(number_of_clusters - 1)) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        finish <= 1'b1;
                    end else begin
                        state    <= FILL;
                        cluster  <= cluster + CLUSTER_W'(1);
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
